// File: rtl/pulse_scheduler_pkg.sv
// Shared definitions for the pulse scheduler: default sizing and the ID-width helper.
package pulse_scheduler_pkg;

   localparam int NCH_DEF = 4;   // default number of channels
   localparam int PW_DEF  = 16;  // default period/counter width

   // Bits needed to encode values 0..v-1, never less than one bit.
   function automatic int min_bit_width(input int v);
      int w;
      w = 1;
      while ((1 << w) < v) w++;
      return w;
   endfunction

endpackage

// File: rtl/pulse_scheduler_rr_arbiter.sv
// Round-robin request picker: first set request at or after ptr_i, wrapping mod NCH.
module rr_arbiter
   import pulse_scheduler_pkg::*;
#(
   parameter  int NCH = NCH_DEF,
   localparam int IDW = min_bit_width(NCH)
) (
   input  logic [NCH-1:0] req_i,
   input  logic [IDW-1:0] ptr_i,
   output logic [NCH-1:0] gnt_o,
   output logic [IDW-1:0] idx_o,
   output logic           any_o
);

   int             pos;
   logic [IDW-1:0] sel;

   // Scan from the pointer and grant the first requester found.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      pos   = 0;
      sel   = '0;
      for (int k = 0; k < NCH; k++) begin
         pos = int'(ptr_i) + k;
         if (pos >= NCH) pos = pos - NCH;
         sel = IDW'(pos);
         if (!any_o && req_i[sel]) begin
            any_o      = 1'b1;
            gnt_o[sel] = 1'b1;
            idx_o      = sel;
         end
      end
   end

endmodule

// File: rtl/pulse_scheduler.sv
// Multi-channel periodic event scheduler: programmable down-counters per channel,
// one pending slot per channel, round-robin serialisation onto a valid/ready stream.
module pulse_scheduler
   import pulse_scheduler_pkg::*;
#(
   parameter  int NCH = NCH_DEF,
   parameter  int PW  = PW_DEF,
   localparam int IDW = min_bit_width(NCH)
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           CFG_WE,
   input  logic [IDW-1:0] CFG_CH,
   input  logic [PW-1:0]  CFG_PERIOD,
   input  logic           CFG_EN,
   output logic           EV_VALID,
   input  logic           EV_READY,
   output logic [IDW-1:0] EV_CH,
   output logic [NCH-1:0] OVERRUN,
   output logic [NCH-1:0] PENDING
);

   logic [NCH-1:0] cfg_hit;
   logic [NCH-1:0] fire;
   logic           cfg_off;

   logic [NCH-1:0] pend_q, pend_d;
   logic [NCH-1:0] ovr_q, ovr_d;
   logic           ev_valid_q, ev_valid_d;
   logic [IDW-1:0] ev_ch_q, ev_ch_d;
   logic [IDW-1:0] ptr_q, ptr_d;

   logic [NCH-1:0] gnt;
   logic [IDW-1:0] gnt_idx;
   logic           gnt_any;
   logic           load;
   logic [NCH-1:0] take;

   // A zero period is treated the same as an explicit disable.
   assign cfg_off = !CFG_EN || (CFG_PERIOD == '0);

   for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic [PW-1:0] period_q;
      logic [PW-1:0] cnt_q;
      logic          en_q;

      // Addresses >= NCH never match, so such writes fall through untouched.
      assign cfg_hit[gi] = CFG_WE && (CFG_CH == IDW'(gi));
      assign fire[gi]    = en_q && (cnt_q == '0);

      // Per-channel down-counter; a config write takes priority over reload/decrement.
      always_ff @(posedge CLK) begin
         if (RST) begin
            period_q <= '0;
            cnt_q    <= '0;
            en_q     <= 1'b0;
         end else if (cfg_hit[gi]) begin
            period_q <= CFG_PERIOD;
            cnt_q    <= CFG_PERIOD - PW'(1);
            en_q     <= !cfg_off;
         end else if (fire[gi]) begin
            cnt_q    <= period_q - PW'(1);
         end else if (en_q) begin
            cnt_q    <= cnt_q - PW'(1);
         end
      end
   end

   rr_arbiter #(.NCH(NCH)) u_arb (
      .req_i (pend_q),
      .ptr_i (ptr_q),
      .gnt_o (gnt),
      .idx_o (gnt_idx),
      .any_o (gnt_any)
   );

   assign load = !ev_valid_q || EV_READY;
   assign take = load ? gnt : '0;

   // Next-state for pending/overrun flags, output register and arbitration pointer.
   always_comb begin
      pend_d     = pend_q;
      ovr_d      = ovr_q;
      ev_valid_d = ev_valid_q;
      ev_ch_d    = ev_ch_q;
      ptr_d      = ptr_q;
      for (int i = 0; i < NCH; i++) begin
         if (take[i]) pend_d[i] = 1'b0;
         if (fire[i]) begin
            // A fire only drops when the slot stays occupied through this edge.
            if (pend_q[i] && !take[i]) ovr_d[i] = 1'b1;
            pend_d[i] = 1'b1;
         end
         if (cfg_hit[i]) begin
            ovr_d[i] = 1'b0;
            if (cfg_off) pend_d[i] = 1'b0;
         end
      end
      if (load) begin
         ev_valid_d = gnt_any;
         if (gnt_any) begin
            ev_ch_d = gnt_idx;
            ptr_d   = (gnt_idx == IDW'(NCH - 1)) ? '0 : gnt_idx + IDW'(1);
         end
      end
   end

   // Control state registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         pend_q     <= '0;
         ovr_q      <= '0;
         ev_valid_q <= 1'b0;
         ev_ch_q    <= '0;
         ptr_q      <= '0;
      end else begin
         pend_q     <= pend_d;
         ovr_q      <= ovr_d;
         ev_valid_q <= ev_valid_d;
         ev_ch_q    <= ev_ch_d;
         ptr_q      <= ptr_d;
      end
   end

   assign EV_VALID = ev_valid_q;
   assign EV_CH    = ev_ch_q;
   assign OVERRUN  = ovr_q;
   assign PENDING  = pend_q;

endmodule
